// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN datapath: activation-unit control codes,
// activation mode encodings, Q6.10 constants and the sequencer state type.
package dqn_pkg;

    localparam logic [3:0]  ACT_CTRL_SIGMOID = 4'b0101;
    localparam logic [3:0]  ACT_CTRL_HOLD    = 4'b0000;
    localparam logic [15:0] FX_ONE           = 16'h0400;

    typedef enum logic [1:0] {
        MODE_SIGMOID   = 2'd0,
        MODE_RELU      = 2'd1,
        MODE_IDENT     = 2'd2,
        MODE_IDENT_ALT = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Only sigmoid goes through the shared unit; every other mode is computed inline.
    function automatic logic uses_unit(input act_mode_t m);
        return m == MODE_SIGMOID;
    endfunction

endpackage

// File: rtl/act_valid_pipe.sv
// Element tracking pipe: each stage carries {valid, address offset} and, from
// LOAD_STAGE onward, the inline result that ends up as the registered write data.
module act_valid_pipe #(
    parameter int DEPTH      = 3,
    parameter int CTRL_STAGE = 1,
    parameter int LOAD_STAGE = 2,
    parameter int OFF_W      = 8,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] fin_data,
    output logic              ctrl_valid,
    output logic              pending,
    output logic [DATA_W-1:0] pre_data,
    output logic              out_valid,
    output logic [OFF_W-1:0]  out_off,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH:1]                  valid_q;
    logic [DEPTH:1][OFF_W-1:0]       off_q;
    logic [DEPTH:LOAD_STAGE][DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            off_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-1:1], in_valid};
            off_q[1] <= in_off;
            for (int k = 2; k <= DEPTH; k++) begin
                off_q[k] <= off_q[k-1];
            end
            data_q[LOAD_STAGE] <= load_data;
            for (int k = LOAD_STAGE + 1; k < DEPTH; k++) begin
                data_q[k] <= data_q[k-1];
            end
            // Final stage doubles as the write-data register; it holds between elements.
            if (valid_q[DEPTH-1]) begin
                data_q[DEPTH] <= fin_data;
            end
        end
    end

    assign ctrl_valid = valid_q[CTRL_STAGE];
    assign pending    = |valid_q[DEPTH-1:1];
    assign pre_data   = data_q[DEPTH-1];
    assign out_valid  = valid_q[DEPTH];
    assign out_off    = off_q[DEPTH];
    assign out_data   = data_q[DEPTH];

endmodule

// File: rtl/activation_sequencer.sv
// Streams a layer's pre-activation vector from the neuron buffer through the
// activation unit (or an inline ReLU/identity path) into the output buffer.
module activation_sequencer
    import dqn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int ACT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        act_ctrl,
    output logic [DATA_W-1:0] act_z,
    input  logic [DATA_W-1:0] act_dout,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output seq_state_t        dbg_state
);

    // ACT_LAT must be at least 1 so the inline result has a stage to wait in.
    localparam int DEPTH = RD_LAT + ACT_LAT + 1;

    seq_state_t        state;
    act_mode_t         mode_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W-1:0] idx;

    logic              ctrl_valid;
    logic              pipe_pending;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] fin_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_off;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] z_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            mode_r  <= MODE_SIGMOID;
            dst_r   <= '0;
            count_r <= '0;
            idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_ISSUE;
                        busy    <= 1'b1;
                        mode_r  <= act_mode_t'(mode);
                        dst_r   <= dst_base;
                        count_r <= count;
                        rd_addr <= src_base;
                        idx     <= '0;
                        rd_en   <= (count != '0);
                    end
                end
                ST_ISSUE: begin
                    if (count_r == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if ({1'b0, idx} == count_r - (ADDR_W+1)'(1)) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        idx     <= idx + ADDR_W'(1);
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Only the write stage may still be occupied: done lands right after it.
                    if (!pipe_pending) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_hold <= '0;
        end else begin
            z_hold <= act_z;
        end
    end

    assign act_z     = ctrl_valid ? rd_data : z_hold;
    assign act_ctrl  = (ctrl_valid && uses_unit(mode_r)) ? ACT_CTRL_SIGMOID : ACT_CTRL_HOLD;
    assign load_data = (mode_r == MODE_RELU && rd_data[DATA_W-1]) ? '0 : rd_data;
    assign fin_data  = uses_unit(mode_r) ? act_dout : pre_data;

    act_valid_pipe #(
        .DEPTH      (DEPTH),
        .CTRL_STAGE (RD_LAT),
        .LOAD_STAGE (RD_LAT + 1),
        .OFF_W      (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (rd_en),
        .in_off     (idx),
        .load_data  (load_data),
        .fin_data   (fin_data),
        .ctrl_valid (ctrl_valid),
        .pending    (pipe_pending),
        .pre_data   (pre_data),
        .out_valid  (out_valid),
        .out_off    (out_off),
        .out_data   (out_data)
    );

    assign wr_en     = out_valid;
    assign wr_addr   = dst_r + out_off;
    assign wr_data   = out_data;
    assign dbg_state = state;

endmodule

// File: tb/tb_activation_sequencer.sv
// Scoreboard bench for activation_sequencer with buffer and activation-unit models.
module tb_activation_sequencer;
    import dqn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  src_base = 8'd0;
    logic [7:0]  dst_base = 8'd0;
    logic [8:0]  count = 9'd0;
    logic        busy, done, rd_en, wr_en;
    logic [7:0]  rd_addr, wr_addr;
    logic [15:0] rd_data = 16'd0;
    logic [15:0] act_dout = 16'd0;
    logic [15:0] act_z, wr_data;
    logic [3:0]  act_ctrl;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:255];
    logic [15:0] dir_data [0:3];
    logic [15:0] dir_exp  [0:3];

    logic [7:0]  rd_exp_q [$];
    logic [23:0] wr_exp_q [$];
    int          rd_cyc_q [$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_wr_cyc = 0;
    logic expect_done = 1'b0;
    logic [1:0] exp_mode = 2'd0;
    logic prev_rd = 1'b0;

    activation_sequencer dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .mode      (mode),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .act_ctrl  (act_ctrl),
        .act_z     (act_z),
        .act_dout  (act_dout),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference behaviour ----------------
    // Piecewise-linear sigmoid in Q6.10.
    function automatic logic [15:0] plan_sigmoid(input logic [15:0] z);
        int x, a, y;
        x = int'($signed(z));
        a = (x < 0) ? -x : x;
        if (a >= 5120)      y = 1024;
        else if (a >= 2432) y = a / 32 + 864;
        else if (a >= 1024) y = a / 8 + 640;
        else                y = a / 4 + 512;
        if (x < 0) y = 1024 - y;
        return y[15:0];
    endfunction

    function automatic logic [15:0] ref_act(input logic [1:0] m, input logic [15:0] z);
        if (m == 2'd0) return plan_sigmoid(z);
        if (m == 2'd1) return ($signed(z) < 0) ? 16'd0 : z;
        return z;
    endfunction

    // Neuron buffer (1-cycle read) and activation unit (1-cycle, holds on 0000).
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (act_ctrl == 4'b0101) act_dout <= plan_sigmoid(act_z);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
        end else begin
            check("act_ctrl", {28'd0, act_ctrl}, (exp_mode == 2'd0 && prev_rd) ? 32'h5 : 32'h0);
            if (prev_rd) check("act_z", {16'd0, act_z}, {16'd0, rd_data});
            if (rd_en) begin
                check("rd_expected", {31'd0, rd_exp_q.size() != 0}, 32'd1);
                if (rd_exp_q.size() != 0) check("rd_addr", {24'd0, rd_addr}, {24'd0, rd_exp_q.pop_front()});
                rd_cyc_q.push_back(cyc);
            end
            if (wr_en) begin
                check("wr_expected", {31'd0, wr_exp_q.size() != 0}, 32'd1);
                if (wr_exp_q.size() != 0)
                    check("wr_addr_data", {8'd0, wr_addr, wr_data}, {8'd0, wr_exp_q.pop_front()});
                check("wr_has_read", {31'd0, rd_cyc_q.size() != 0}, 32'd1);
                if (rd_cyc_q.size() != 0) check("wr_latency", cyc - rd_cyc_q.pop_front(), 32'd3);
                last_wr_cyc = cyc;
            end
            if (done) begin
                check("done_expected", {31'd0, expect_done}, 32'd1);
                check("done_busy_low", {31'd0, busy}, 32'd0);
                done_cyc = cyc;
                done_cnt++;
            end
            prev_rd = rd_en;
        end
    end

    // ---------------- driver ----------------
    task automatic run_job(input logic [1:0] m, input logic [7:0] src, input logic [7:0] dst,
                           input int cnt, input bit directed, input bit poke_busy, input bit poke_done);
        int issue_cyc, d0, waited;
        logic [15:0] z;
        logic [7:0]  a;
        for (int i = 0; i < cnt; i++) begin
            a = src + 8'(i);
            z = directed ? dir_data[i] : 16'($urandom);
            mem[a] = z;
            rd_exp_q.push_back(a);
            wr_exp_q.push_back({dst + 8'(i), directed ? dir_exp[i] : ref_act(m, z)});
        end
        exp_mode = m;
        expect_done = 1'b1;
        d0 = done_cnt;
        start = 1'b1; mode = m; src_base = src; dst_base = dst; count = 9'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        issue_cyc = cyc;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (poke_busy) begin
            start = 1'b1; mode = ~m; src_base = 8'h33; dst_base = 8'h44; count = 9'd5;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waited = 0;
        while (done_cnt == d0 && waited < cnt + 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check("done_seen", {31'd0, done_cnt != d0}, 32'd1);
        if (done_cnt != d0) begin
            check("done_latency", done_cyc - issue_cyc, (cnt == 0) ? 32'd1 : 32'(cnt + 3));
            if (cnt > 0) check("done_after_last_wr", done_cyc - last_wr_cyc, 32'd1);
            check("writes_complete", wr_exp_q.size(), 32'd0);
            if (poke_done) begin
                start = 1'b1; mode = m; src_base = 8'h55; dst_base = 8'h66; count = 9'd4;
            end
        end
        expect_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    {31'd0, busy}, 32'd0);
        check({tag, "_done"},    {31'd0, done}, 32'd0);
        check({tag, "_rd_en"},   {31'd0, rd_en}, 32'd0);
        check({tag, "_wr_en"},   {31'd0, wr_en}, 32'd0);
        check({tag, "_rd_addr"}, {24'd0, rd_addr}, 32'd0);
        check({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
        check({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        check({tag, "_act_z"},   {16'd0, act_z}, 32'd0);
        check({tag, "_act_ctrl"},{28'd0, act_ctrl}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] z;
        int d_before;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sigmoid through the unit.
        dir_data[0] = 16'h0000; dir_data[1] = 16'h0800; dir_data[2] = 16'hF800; dir_data[3] = 16'h1800;
        dir_exp[0]  = 16'h0200; dir_exp[1]  = 16'h0380; dir_exp[2]  = 16'h0080; dir_exp[3]  = 16'h0400;
        run_job(2'd0, 8'h10, 8'h80, 4, 1'b1, 1'b0, 1'b0);

        // Inline ReLU.
        dir_data[0] = 16'hF800; dir_data[1] = 16'h0400; dir_data[2] = 16'h0000;
        dir_exp[0]  = 16'h0000; dir_exp[1]  = 16'h0400; dir_exp[2]  = 16'h0000;
        run_job(2'd1, 8'h20, 8'h90, 3, 1'b1, 1'b0, 1'b0);

        // Zero-length job.
        run_job(2'd2, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);

        // Address wrap, start while busy, start in DONE, then immediate next job.
        run_job(2'($urandom_range(0, 3)), 8'hFE, 8'hFF, 3, 1'b0, 1'b1, 1'b1);
        run_job(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 5, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            run_job(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    $urandom_range(1, 20), 1'b0, 1'b0, 1'b0);
        end

        // Full 256-element job.
        run_job(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 256, 1'b0, 1'b0, 1'b0);

        // Reset during DRAIN of an 8-element job.
        for (int i = 0; i < 8; i++) begin
            z = 16'($urandom);
            mem[8'h40 + 8'(i)] = z;
            rd_exp_q.push_back(8'h40 + 8'(i));
            wr_exp_q.push_back({8'hC0 + 8'(i), ref_act(2'd0, z)});
        end
        exp_mode = 2'd0;
        expect_done = 1'b0;
        d_before = done_cnt;
        start = 1'b1; mode = 2'd0; src_base = 8'h40; dst_base = 8'hC0; count = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("drain_state", {30'd0, dbg_state}, {30'd0, ST_DRAIN});
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        rd_exp_q.delete();
        wr_exp_q.delete();
        rd_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt, d_before);
        check("idle_after_abort", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        run_job(2'($urandom_range(0, 3)), 8'h40, 8'hC0, 2, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("final_rd_queue_empty", rd_exp_q.size(), 32'd0);
        check("final_wr_queue_empty", wr_exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
